id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have clk_i  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have rst_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have stall_i  in  1  hold stage contents.
REQ-004 SHALL have flush_i  in  1  replace stage contents with bubble.
REQ-005 SHALL have valid_i  in  1  decode stage presents a real instruction.
REQ-006 SHALL have pc_i, rs1_data_i, rs2_data_i, imm_i  in  32 each  PC, register-file reads, sign-extended immediate.
REQ-007 SHALL have rs1_addr_i, rs2_addr_i, rd_addr_i  in  5 each  source/destination register indices.
REQ-008 SHALL have alu_ctrl_i  in  4  ALU operation code, passed through unchanged.
REQ-009 SHALL have src_sel_i  in  2  bit0: op1 = PC (1) / rs1 (0); bit1: op2 = imm (1) / rs2 (0).
REQ-010 SHALL have ctrl_i  in  4  {branch, mem_write, mem_read, reg_write}.
REQ-011 SHALL have exmem_rd_i, memwb_rd_i  in  5 each  destination indices of later stages.
REQ-012 SHALL have exmem_we_i, memwb_we_i  in  1 each  later-stage register-write enables.
REQ-013 SHALL have exmem_data_i, memwb_data_i  in  32 each  later-stage results.
REQ-014 SHALL have op1_o, op2_o  out  32 each  ALU operands.
REQ-015 SHALL have alu_ctrl_o  out  4;  store_data_o  out  32 forwarded rs2;  rd_addr_o  out  5;  ctrl_o  out  4;  pc_o  out  32.
REQ-016 SHALL have valid_o  out  1  stage holds a real instruction;  hazard_o  out  1  load-use stall request to upstream.

Function
REQ-017 Each edge: flush_i=1 SHALL load bubble; else hazard_o=1 SHALL load bubble; else stall_i=1 SHALL hold; else SHALL capture all *_i fields.
REQ-018 Bubble SHALL be valid=0, ctrl=0000, rd=0, alu_ctrl=0000, data fields 0.
REQ-019 Forwarded rsN value SHALL be exmem_data_i if exmem_we_i && exmem_rd_i==stored rsN && rsN!=0; else memwb_data_i under the same test; else stored rsN data (EX/MEM wins over MEM/WB).
REQ-020 Register x0 SHALL never be forwarded; its value SHALL be the stored data.
REQ-021 op1_o SHALL be stored PC if src_sel bit0 else forwarded rs1; op2_o SHALL be stored imm if bit1 else forwarded rs2; store_data_o SHALL always be forwarded rs2.
REQ-022 Forwarding muxes SHALL be combinational from stored state and forwarding inputs, zero added latency; stage latency is exactly one cycle.
REQ-023 hazard_o SHALL be combinational: 1 when valid_o && ctrl_o mem_read && rd_addr_o!=0 && valid_i && (rd_addr_o==rs1_addr_i || rd_addr_o==rs2_addr_i).
REQ-024 hazard_o SHALL be suppressed while flush_i=1; stall_i=1 SHALL NOT mask hazard_o.
REQ-025 stall_i and flush_i together SHALL flush.

Reset
REQ-026 While rst_i=1 all stored fields SHALL be bubble values and pc 0, taking effect without a clock edge; valid_o=0, hazard_o=0, all outputs 0.
REQ-027 Reset asserted mid-stall or mid-hazard SHALL discard held instruction; first edge after release SHALL capture normally.

Configuration
REQ-028 With macro ID_EX_FORWARD_EN defined, REQ-019 forwarding SHALL be implemented.
REQ-029 Without ID_EX_FORWARD_EN, forwarded values SHALL equal stored data, forwarding inputs SHALL be ignored except for hazard, and hazard_o SHALL additionally assert for any valid_i source match (non-zero) against rd_addr_o with reg_write, or against exmem_rd_i with exmem_we_i.

Verification
REQ-030 rst_i=1 mid-run, no clock -> all outputs 0 immediately; release, capture pc_i=0x100 -> pc_o=0x100 next cycle.
REQ-031 stored rs1=5, rs1_data=0x11; exmem_rd=5 we=1 data=0x22; memwb_rd=5 we=1 data=0x33 -> op1_o=0x22; drop exmem_we -> 0x33.
REQ-032 stored rs2=0, exmem_rd=0 we=1 data=0xFF, rs2_data=0 -> op2_o=0, store_data_o=0.
REQ-033 lw x7 in stage, incoming add rs1=x7 valid -> hazard_o=1, next cycle valid_o=0, ctrl_o=0; add captured the cycle after.
REQ-034 stall_i=1 three cycles with changing inputs -> outputs constant; stall_i=flush_i=1 -> bubble next cycle.
REQ-035 src_sel=01, pc=0x40, alu_ctrl=0101 -> op1_o=0x40, alu_ctrl_o=0101; without ID_EX_FORWARD_EN, exmem_rd==rs1 case of REQ-031 -> hazard_o=1.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding muxes and load-use hazard detection.
// Optional build macro ID_EX_FORWARD_EN enables EX/MEM and MEM/WB operand forwarding.
module id_ex_stage (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        stall_i,
    input  logic        flush_i,
    input  logic        valid_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [31:0] imm_i,
    input  logic [4:0]  rs1_addr_i,
    input  logic [4:0]  rs2_addr_i,
    input  logic [4:0]  rd_addr_i,
    input  logic [3:0]  alu_ctrl_i,
    input  logic [1:0]  src_sel_i,
    input  logic [3:0]  ctrl_i,
    input  logic [4:0]  exmem_rd_i,
    input  logic [4:0]  memwb_rd_i,
    input  logic        exmem_we_i,
    input  logic        memwb_we_i,
    input  logic [31:0] exmem_data_i,
    input  logic [31:0] memwb_data_i,
    output logic [31:0] op1_o,
    output logic [31:0] op2_o,
    output logic [3:0]  alu_ctrl_o,
    output logic [31:0] store_data_o,
    output logic [4:0]  rd_addr_o,
    output logic [3:0]  ctrl_o,
    output logic [31:0] pc_o,
    output logic        valid_o,
    output logic        hazard_o
);

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
        logic [3:0]  alu_ctrl;
        logic [1:0]  src_sel;
        logic [3:0]  ctrl;
    } stage_t;

    stage_t      r_stage;
    stage_t      w_capture;
    logic [31:0] w_fwd_rs1;
    logic [31:0] w_fwd_rs2;
    logic        w_rd_src_match;
    logic        w_hazard;

    // EX/MEM has priority over MEM/WB; x0 always reads its stored value.
    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  src,
        input logic [31:0] stored,
        input logic        ex_we,
        input logic [4:0]  ex_rd,
        input logic [31:0] ex_data,
        input logic        mw_we,
        input logic [4:0]  mw_rd,
        input logic [31:0] mw_data
    );
        if (src != 5'd0 && ex_we && ex_rd == src) begin
            return ex_data;
        end else if (src != 5'd0 && mw_we && mw_rd == src) begin
            return mw_data;
        end else begin
            return stored;
        end
    endfunction

    // Gather the decode-stage fields into the stage record.
    always_comb begin
        w_capture          = '0;
        w_capture.valid    = valid_i;
        w_capture.pc       = pc_i;
        w_capture.rs1_data = rs1_data_i;
        w_capture.rs2_data = rs2_data_i;
        w_capture.imm      = imm_i;
        w_capture.rs1_addr = rs1_addr_i;
        w_capture.rs2_addr = rs2_addr_i;
        w_capture.rd_addr  = rd_addr_i;
        w_capture.alu_ctrl = alu_ctrl_i;
        w_capture.src_sel  = src_sel_i;
        w_capture.ctrl     = ctrl_i;
    end

    assign w_rd_src_match = valid_i && (r_stage.rd_addr != 5'd0) &&
                            ((r_stage.rd_addr == rs1_addr_i) || (r_stage.rd_addr == rs2_addr_i));

`ifdef ID_EX_FORWARD_EN
    assign w_fwd_rs1 = fwd_sel(r_stage.rs1_addr, r_stage.rs1_data, exmem_we_i, exmem_rd_i,
                               exmem_data_i, memwb_we_i, memwb_rd_i, memwb_data_i);
    assign w_fwd_rs2 = fwd_sel(r_stage.rs2_addr, r_stage.rs2_data, exmem_we_i, exmem_rd_i,
                               exmem_data_i, memwb_we_i, memwb_rd_i, memwb_data_i);

    // Only a load in flight needs a bubble; everything else is forwarded.
    always_comb begin
        w_hazard = 1'b0;
        if (r_stage.valid && r_stage.ctrl[1] && w_rd_src_match) begin
            w_hazard = 1'b1;
        end else begin
            w_hazard = 1'b0;
        end
    end
`else
    logic w_unused_fwd;

    assign w_fwd_rs1    = r_stage.rs1_data;
    assign w_fwd_rs2    = r_stage.rs2_data;
    assign w_unused_fwd = ^{memwb_rd_i, memwb_we_i, memwb_data_i, exmem_data_i,
                            r_stage.rs1_addr, r_stage.rs2_addr};

    // Without forwarding, stall on any pending write to a source register.
    always_comb begin
        w_hazard = 1'b0;
        if (r_stage.valid && (r_stage.ctrl[1] || r_stage.ctrl[0]) && w_rd_src_match) begin
            w_hazard = 1'b1;
        end else if (valid_i && exmem_we_i && (exmem_rd_i != 5'd0) &&
                     ((exmem_rd_i == rs1_addr_i) || (exmem_rd_i == rs2_addr_i))) begin
            w_hazard = 1'b1;
        end else begin
            w_hazard = 1'b0;
        end
    end
`endif

    assign hazard_o = w_hazard && !flush_i && !rst_i;

    // Stage register: flush and hazard insert a bubble, stall holds.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stage <= '0;
        end else if (flush_i || hazard_o) begin
            r_stage <= '0;
        end else if (!stall_i) begin
            r_stage <= w_capture;
        end
    end

    assign op1_o        = r_stage.src_sel[0] ? r_stage.pc  : w_fwd_rs1;
    assign op2_o        = r_stage.src_sel[1] ? r_stage.imm : w_fwd_rs2;
    assign store_data_o = w_fwd_rs2;
    assign alu_ctrl_o   = r_stage.alu_ctrl;
    assign rd_addr_o    = r_stage.rd_addr;
    assign ctrl_o       = r_stage.ctrl;
    assign pc_o         = r_stage.pc;
    assign valid_o      = r_stage.valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage; expectations follow ID_EX_FORWARD_EN when defined.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk_i = 1'b0;
    logic        rst_i, stall_i, flush_i, valid_i;
    logic [31:0] pc_i, rs1_data_i, rs2_data_i, imm_i;
    logic [4:0]  rs1_addr_i, rs2_addr_i, rd_addr_i;
    logic [3:0]  alu_ctrl_i, ctrl_i;
    logic [1:0]  src_sel_i;
    logic [4:0]  exmem_rd_i, memwb_rd_i;
    logic        exmem_we_i, memwb_we_i;
    logic [31:0] exmem_data_i, memwb_data_i;
    logic [31:0] op1_o, op2_o, store_data_o, pc_o;
    logic [3:0]  alu_ctrl_o, ctrl_o;
    logic [4:0]  rd_addr_o;
    logic        valid_o, hazard_o;

    int checks   = 0;
    int failures = 0;

    id_ex_stage dut (
        .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
        .pc_i(pc_i), .rs1_data_i(rs1_data_i), .rs2_data_i(rs2_data_i), .imm_i(imm_i),
        .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i), .rd_addr_i(rd_addr_i),
        .alu_ctrl_i(alu_ctrl_i), .src_sel_i(src_sel_i), .ctrl_i(ctrl_i),
        .exmem_rd_i(exmem_rd_i), .memwb_rd_i(memwb_rd_i),
        .exmem_we_i(exmem_we_i), .memwb_we_i(memwb_we_i),
        .exmem_data_i(exmem_data_i), .memwb_data_i(memwb_data_i),
        .op1_o(op1_o), .op2_o(op2_o), .alu_ctrl_o(alu_ctrl_o), .store_data_o(store_data_o),
        .rd_addr_o(rd_addr_o), .ctrl_o(ctrl_o), .pc_o(pc_o), .valid_o(valid_o), .hazard_o(hazard_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] a1,
                         input logic [31:0] d1, input logic [4:0] a2, input logic [31:0] d2,
                         input logic [31:0] imm, input logic [4:0] rd, input logic [3:0] alu,
                         input logic [1:0] sel, input logic [3:0] ctrl);
        valid_i = v;   pc_i = pc;   rs1_addr_i = a1; rs1_data_i = d1;
        rs2_addr_i = a2; rs2_data_i = d2; imm_i = imm; rd_addr_i = rd;
        alu_ctrl_i = alu; src_sel_i = sel; ctrl_i = ctrl;
    endtask

    task automatic set_fwd(input logic ewe, input logic [4:0] erd, input logic [31:0] edata,
                           input logic mwe, input logic [4:0] mrd, input logic [31:0] mdata);
        exmem_we_i = ewe; exmem_rd_i = erd; exmem_data_i = edata;
        memwb_we_i = mwe; memwb_rd_i = mrd; memwb_data_i = mdata;
    endtask

    initial begin
        rst_i = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
        drive(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 4'h0, 2'b00, 4'h0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #2;
        check_eq("reset_valid", {31'd0, valid_o}, 32'h0);
        check_eq("reset_pc", pc_o, 32'h0);

        // Capture, then asynchronous reset mid-run, then recapture.
        drive(1'b1, 32'h100, 5'd1, 32'hA, 5'd2, 32'hB, 32'h0, 5'd3, 4'h1, 2'b00, 4'h1);
        rst_i = 1'b0;
        tick();
        check_eq("cap_pc", pc_o, 32'h100);
        check_eq("cap_valid", {31'd0, valid_o}, 32'h1);
        rst_i = 1'b1;
        #1;
        check_eq("async_rst_all", {pc_o, op1_o, op2_o, store_data_o} == 128'd0 ? 32'h0 : 32'h1, 32'h0);
        check_eq("async_rst_ctl", {17'd0, valid_o, hazard_o, ctrl_o, alu_ctrl_o, rd_addr_o}, 32'h0);
        rst_i = 1'b0;
        tick();
        check_eq("post_rst_pc", pc_o, 32'h100);

        // Forwarding priority on rs1.
        drive(1'b1, 32'h10, 5'd5, 32'h11, 5'd0, 32'h0, 32'h0, 5'd9, 4'h0, 2'b00, 4'h1);
        tick();
        drive(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 4'h0, 2'b00, 4'h0);
        set_fwd(1'b1, 5'd5, 32'h22, 1'b1, 5'd5, 32'h33);
        #1;
        check_eq("fwd_exmem", op1_o, FWD ? 32'h22 : 32'h11);
        exmem_we_i = 1'b0;
        #1;
        check_eq("fwd_memwb", op1_o, FWD ? 32'h33 : 32'h11);
        memwb_we_i = 1'b0;
        #1;
        check_eq("fwd_none", op1_o, 32'h11);
        exmem_we_i = 1'b1;
        valid_i = 1'b1; rs1_addr_i = 5'd5;
        #1;
        check_eq("haz_exmem_src", {31'd0, hazard_o}, FWD ? 32'h0 : 32'h1);
        exmem_we_i = 1'b0; rs1_addr_i = 5'd0; rs2_addr_i = 5'd9;
        #1;
        check_eq("haz_regwrite_src", {31'd0, hazard_o}, FWD ? 32'h0 : 32'h1);
        valid_i = 1'b0;
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        tick();

        // x0 never forwarded.
        drive(1'b1, 32'h20, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 4'h0, 2'b00, 4'h0);
        tick();
        drive(1'b0, 32'h0, 5'd0, 32'h0, 5'd0, 32'h0, 32'h0, 5'd0, 4'h0, 2'b00, 4'h0);
        set_fwd(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hFF);
        #1;
        check_eq("x0_op2", op2_o, 32'h0);
        check_eq("x0_store", store_data_o, 32'h0);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Load-use: lw x7 followed by add reading x7.
        drive(1'b1, 32'h30, 5'd2, 32'h0, 5'd0, 32'h0, 32'h4, 5'd7, 4'h0, 2'b10, 4'b0011);
        tick();
        drive(1'b1, 32'h50, 5'd7, 32'h0, 5'd3, 32'h0, 32'h0, 5'd8, 4'h0, 2'b00, 4'b0001);
        #1;
        check_eq("lu_hazard", {31'd0, hazard_o}, 32'h1);
        tick();
        check_eq("lu_bubble_valid", {31'd0, valid_o}, 32'h0);
        check_eq("lu_bubble_ctrl", {28'd0, ctrl_o}, 32'h0);
        tick();
        check_eq("lu_add_pc", pc_o, 32'h50);
        check_eq("lu_add_rd", {27'd0, rd_addr_o}, 32'h8);

        // Stall holds for three cycles with changing inputs, then stall+flush.
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h60 + 32'(i * 16), 5'd1, 32'h0, 5'd2, 32'h0, 32'h0, 5'd4, 4'h2, 2'b00, 4'h1);
            tick();
            check_eq("stall_hold_pc", pc_o, 32'h50);
        end
        flush_i = 1'b1;
        tick();
        check_eq("stall_flush_valid", {31'd0, valid_o}, 32'h0);
        check_eq("stall_flush_pc", pc_o, 32'h0);
        stall_i = 1'b0; flush_i = 1'b0;

        // Operand source selection.
        drive(1'b1, 32'h40, 5'd1, 32'h99, 5'd2, 32'h77, 32'h1234, 5'd10, 4'b0101, 2'b01, 4'h1);
        tick();
        check_eq("sel_op1_pc", op1_o, 32'h40);
        check_eq("sel_op2_rs2", op2_o, 32'h77);
        check_eq("sel_alu", {28'd0, alu_ctrl_o}, 32'h5);
        drive(1'b1, 32'h44, 5'd1, 32'h99, 5'd2, 32'h77, 32'h1234, 5'd11, 4'h0, 2'b10, 4'h1);
        tick();
        check_eq("sel_op1_rs1", op1_o, 32'h99);
        check_eq("sel_op2_imm", op2_o, 32'h1234);
        check_eq("sel_store", store_data_o, 32'h77);

        // Hazard vs stall/flush, then reset mid-hazard.
        drive(1'b1, 32'h70, 5'd1, 32'h0, 5'd0, 32'h0, 32'h0, 5'd7, 4'h0, 2'b00, 4'b0010);
        tick();
        drive(1'b1, 32'h200, 5'd7, 32'h0, 5'd0, 32'h0, 32'h0, 5'd12, 4'h3, 2'b00, 4'h1);
        stall_i = 1'b1;
        #1;
        check_eq("haz_under_stall", {31'd0, hazard_o}, 32'h1);
        flush_i = 1'b1;
        #1;
        check_eq("haz_flush_mask", {31'd0, hazard_o}, 32'h0);
        flush_i = 1'b0;
        rst_i = 1'b1;
        #1;
        check_eq("rst_haz", {30'd0, hazard_o, valid_o}, 32'h0);
        rst_i = 1'b0; stall_i = 1'b0;
        tick();
        check_eq("rst_recap_pc", pc_o, 32'h200);
        check_eq("rst_recap_alu", {28'd0, alu_ctrl_o}, 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
